mem_rr_arbiter: RTL and testbench

//  Round-robin arbiter sharing one dp_ram dmem-style port between N_REQ cache-line requesters (per-core D/I caches).

---
 rtl/mem_rr_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_rr_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one cache-line memory port between N_REQ requesters.
// Optional per-requester grant counters are enabled by defining MEM_ARB_STATS_EN.

module mem_rr_slot #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  strobe,
    input  logic                  clear,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] wdata_in,
    input  logic                  rw_in,
    output logic                  pending,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  rw
);
    // A strobe is only taken when the slot is empty, so the captured request
    // stays stable for the whole ISSUE/WAIT window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
            addr    <= '0;
            wdata   <= '0;
            rw      <= 1'b0;
        end else if (clear) begin
            pending <= 1'b0;
        end else if (strobe && !pending) begin
            pending <= 1'b1;
            addr    <= addr_in;
            wdata   <= wdata_in;
            rw      <= rw_in;
        end
    end
endmodule

module mem_rr_arbiter #(
    parameter int N_REQ      = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            s_strobe_i,
    input  logic [N_REQ*ADDR_WIDTH-1:0] s_addr_i,
    input  logic [N_REQ*DATA_WIDTH-1:0] s_wdata_i,
    input  logic [N_REQ-1:0]            s_rw_i,
    output logic [N_REQ-1:0]            s_done_o,
    output logic [DATA_WIDTH-1:0]       s_rdata_o,
    output logic                        m_strobe_o,
    output logic [ADDR_WIDTH-1:0]       m_addr_o,
    output logic [DATA_WIDTH-1:0]       m_wdata_o,
    output logic                        m_rw_o,
    input  logic [DATA_WIDTH-1:0]       m_rdata_i,
    input  logic                        m_done_i,
    output logic [N_REQ*32-1:0]         stat_grants_o
);
    localparam int PW = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

    state_t                state;
    logic [PW-1:0]         grant;
    logic [PW-1:0]         rr_ptr;
    logic [N_REQ-1:0]      pending;
    logic [ADDR_WIDTH-1:0] buf_addr  [N_REQ];
    logic [DATA_WIDTH-1:0] buf_wdata [N_REQ];
    logic                  buf_rw    [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_slot
        mem_rr_slot #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_slot (
            .clk      (clk),
            .rst      (rst),
            .strobe   (s_strobe_i[i]),
            .clear    (s_done_o[i]),
            .addr_in  (s_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH]),
            .wdata_in (s_wdata_i[i*DATA_WIDTH +: DATA_WIDTH]),
            .rw_in    (s_rw_i[i]),
            .pending  (pending[i]),
            .addr     (buf_addr[i]),
            .wdata    (buf_wdata[i]),
            .rw       (buf_rw[i])
        );
    end

    // Scan from rr_ptr upward with wrap; descending loop leaves the nearest hit.
    logic          arb_found;
    logic [PW-1:0] arb_idx;
    logic [PW-1:0] scan_idx;
    logic [PW-1:0] rr_nxt;

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        scan_idx  = '0;
        for (int k = N_REQ-1; k >= 0; k--) begin
            scan_idx = PW'((int'(rr_ptr) + k) % N_REQ);
            if (pending[scan_idx]) begin
                arb_found = 1'b1;
                arb_idx   = scan_idx;
            end
        end
        rr_nxt = PW'((int'(arb_idx) + 1) % N_REQ);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            case (state)
                IDLE, GAP: begin
                    if (arb_found) begin
                        grant  <= arb_idx;
                        rr_ptr <= rr_nxt;
                        state  <= ISSUE;
                    end else begin
                        state  <= IDLE;
                    end
                end
                ISSUE:   state <= WAIT;
                WAIT:    if (m_done_i) state <= GAP;
                default: state <= IDLE;
            endcase
        end
    end

    logic active;
    logic done_hit;

    assign active     = (state == ISSUE) || (state == WAIT);
    assign done_hit   = (state == WAIT) && m_done_i;
    assign m_strobe_o = (state == ISSUE);
    assign m_addr_o   = active ? buf_addr[grant]  : '0;
    assign m_wdata_o  = active ? buf_wdata[grant] : '0;
    assign m_rw_o     = active ? buf_rw[grant]    : 1'b0;
    assign s_rdata_o  = done_hit ? m_rdata_i : '0;

    always_comb begin
        s_done_o = '0;
        if (done_hit) s_done_o[grant] = 1'b1;
    end

`ifdef MEM_ARB_STATS_EN
    logic [31:0] stat_cnt [N_REQ];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) stat_cnt[i] <= '0;
        end else if (state == ISSUE && stat_cnt[grant] != 32'hFFFF_FFFF) begin
            stat_cnt[grant] <= stat_cnt[grant] + 32'd1;
        end
    end

    for (genvar i = 0; i < N_REQ; i++) begin : g_stat
        assign stat_grants_o[i*32 +: 32] = stat_cnt[i];
    end
`else
    assign stat_grants_o = '0;
`endif

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Self-checking bench for mem_rr_arbiter: directed scenarios plus random traffic,
// compared each cycle against a transaction-level model of the arbiter.

module tb_mem_rr_arbiter;
    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 128;
    localparam int L  = 4;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    s_strobe_i = '0;
    logic [N*AW-1:0] s_addr_i   = '0;
    logic [N*DW-1:0] s_wdata_i  = '0;
    logic [N-1:0]    s_rw_i     = '0;
    logic [N-1:0]    s_done_o;
    logic [DW-1:0]   s_rdata_o;
    logic            m_strobe_o;
    logic [AW-1:0]   m_addr_o;
    logic [DW-1:0]   m_wdata_o;
    logic            m_rw_o;
    logic [DW-1:0]   m_rdata_i;
    logic            m_done_i;
    logic [N*32-1:0] stat_grants_o;

    always #5 clk = ~clk;

    mem_rr_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .s_strobe_i(s_strobe_i), .s_addr_i(s_addr_i), .s_wdata_i(s_wdata_i), .s_rw_i(s_rw_i),
        .s_done_o(s_done_o), .s_rdata_o(s_rdata_o),
        .m_strobe_o(m_strobe_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o), .m_rw_o(m_rw_o),
        .m_rdata_i(m_rdata_i), .m_done_i(m_done_i), .stat_grants_o(stat_grants_o)
    );

    function automatic logic [DW-1:0] init_line(int k);
        return {32'(k) * 32'h0101_0101, 32'hDEAD_0000 | 32'(k), ~32'(k), 32'h1234_5678 + 32'(k)};
    endfunction

    // Memory device: done pulses L+1 cycles after the strobe cycle; reset with the arbiter.
    logic [DW-1:0] mem_store [16];
    int            mt;
    logic [31:0]   m_a;
    logic [DW-1:0] m_wd;
    logic          m_w;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mt        <= 0;
            m_done_i  <= 1'b0;
            m_rdata_i <= '0;
            m_a       <= '0;
            m_wd      <= '0;
            m_w       <= 1'b0;
            for (int k = 0; k < 16; k++) mem_store[k] <= init_line(k);
        end else begin
            m_done_i  <= (mt == 1);
            m_rdata_i <= (mt == 1 && !m_w) ? mem_store[m_a[9:6]] : '0;
            if (mt == 1 && m_w) mem_store[m_a[9:6]] <= m_wd;
            if (m_strobe_o) begin
                mt   <= L;
                m_a  <= m_addr_o;
                m_wd <= m_wdata_o;
                m_w  <= m_rw_o;
            end else if (mt != 0) begin
                mt <= mt - 1;
            end
        end
    end

    // Reference model state (transaction level)
    bit            r_pend [N];
    logic [31:0]   r_addr [N];
    logic [DW-1:0] r_wd   [N];
    bit            r_rw   [N];
    logic [DW-1:0] ref_mem [16];
    int  rr, g, exp_done, arb_ok, cyc;
    bit  busy;
    int  gcnt [N];

    // Observation records
    int            ndone [N];
    int            last_done [N];
    logic [DW-1:0] last_rdata [N];
    int            last_mstb;
    logic [31:0]   mstb_addr;
    int            n_done_total;
    int            seq [$];
    logic [N*32-1:0] stat_snap;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            r_pend[i] = 0; gcnt[i] = 0;
        end
        for (int k = 0; k < 16; k++) ref_mem[k] = init_line(k);
        rr = 0; busy = 0; arb_ok = 0; cyc = 0; g = 0; exp_done = 0;
    endtask

    function automatic logic [N*32-1:0] exp_stats();
        logic [N*32-1:0] es = '0;
`ifdef MEM_ARB_STATS_EN
        for (int i = 0; i < N; i++) es[i*32 +: 32] = 32'(gcnt[i]);
`endif
        return es;
    endfunction

    task automatic set_req(input int i, input logic [31:0] a, input logic [DW-1:0] d, input logic w);
        s_addr_i[i*AW +: AW]  = a;
        s_wdata_i[i*DW +: DW] = d;
        s_rw_i[i]             = w;
    endtask

    // One clock cycle: drive strobes, check outputs at negedge against the model.
    task automatic step(input logic [N-1:0] stb);
        logic [N-1:0]  e_done;
        logic [DW-1:0] e_rd;
        bit            dn, act;
        s_strobe_i = stb;
        @(negedge clk);
        if (!busy && cyc >= arb_ok) begin
            for (int k = 0; k < N; k++) begin
                if (!busy && r_pend[(rr + k) % N]) begin
                    g = (rr + k) % N;
                    busy = 1;
                    exp_done = cyc + 2 + L;
                    rr = (g + 1) % N;
                    gcnt[g]++;
                end
            end
        end
        dn  = busy && (cyc == exp_done);
        act = busy && (cyc >= exp_done - 1 - L);
        e_done = '0;
        e_rd   = '0;
        if (dn) begin
            e_done[g] = 1'b1;
            if (!r_rw[g]) e_rd = ref_mem[r_addr[g][9:6]];
        end
        chk("m_strobe", m_strobe_o, busy && (cyc == exp_done - 1 - L));
        chk("m_addr",   m_addr_o,  act ? r_addr[g] : '0);
        chk("m_wdata",  m_wdata_o, act ? r_wd[g]   : '0);
        chk("m_rw",     m_rw_o,    act ? r_rw[g]   : 1'b0);
        chk("s_done",   s_done_o,  e_done);
        chk("s_rdata",  s_rdata_o, e_rd);
        if (dn) chk("stats", stat_grants_o, exp_stats());
        for (int i = 0; i < N; i++) begin
            if (s_done_o[i]) begin
                ndone[i]++; last_done[i] = cyc; last_rdata[i] = s_rdata_o;
                seq.push_back(i); n_done_total++;
                if (n_done_total == 20) stat_snap = stat_grants_o;
            end
        end
        if (m_strobe_o) begin
            last_mstb = cyc; mstb_addr = m_addr_o;
        end
        for (int i = 0; i < N; i++) begin
            if (stb[i] && !r_pend[i]) begin
                r_pend[i] = 1;
                r_addr[i] = s_addr_i[i*AW +: AW];
                r_wd[i]   = s_wdata_i[i*DW +: DW];
                r_rw[i]   = s_rw_i[i];
            end
        end
        if (dn) begin
            if (r_rw[g]) ref_mem[r_addr[g][9:6]] = r_wd[g];
            r_pend[g] = 0; busy = 0; arb_ok = cyc + 1;
        end
        @(posedge clk); #1;
        s_strobe_i = '0;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step('0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_strobe_i = '0;
        #1;
        chk("rst_m_strobe", m_strobe_o, 1'b0);
        chk("rst_m_addr",   m_addr_o, '0);
        chk("rst_m_wdata",  m_wdata_o, '0);
        chk("rst_m_rw",     m_rw_o, 1'b0);
        chk("rst_s_done",   s_done_o, '0);
        chk("rst_s_rdata",  s_rdata_o, '0);
        chk("rst_stats",    stat_grants_o, '0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, nd0, viol;
        logic [DW-1:0] d;
        logic [N-1:0]  stb;
        logic [N*32-1:0] t7_exp;
        for (int i = 0; i < N; i++) begin
            ndone[i] = 0; last_done[i] = -1; last_rdata[i] = '0;
        end
        last_mstb = -1; mstb_addr = '0; n_done_total = 0; stat_snap = '0;
        @(posedge clk); #1;
        do_reset();

        // T1 single read
        set_req(0, BASE + 32'h40, '0, 1'b0);
        base = cyc;
        step(2'b01);
        idle(9);
        chk("t1_mstb_cycle", 32'(last_mstb - base), 32'd2);
        chk("t1_done_cycle", 32'(last_done[0] - base), 32'd7);
        chk("t1_rdata", last_rdata[0], init_line(1));

        // T2 write then read back
        d = {$urandom, $urandom, $urandom, $urandom};
        set_req(1, BASE + 32'h100, d, 1'b1);
        step(2'b10);
        idle(8);
        set_req(1, BASE + 32'h100, '0, 1'b0);
        step(2'b10);
        idle(8);
        chk("t2_readback", last_rdata[1], d);

        // T3 simultaneous strobes, then again to show the pointer wrapped to 0
        set_req(0, BASE + 32'h80, '0, 1'b0);
        set_req(1, BASE + 32'hC0, '0, 1'b0);
        base = cyc;
        step(2'b11);
        idle(15);
        chk("t3_req0_done", 32'(last_done[0] - base), 32'd7);
        chk("t3_req1_done", 32'(last_done[1] - base), 32'd14);
        chk("t3_req1_mstb", 32'(last_mstb - base), 32'd9);
        base = cyc;
        step(2'b11);
        idle(15);
        chk("t3_rr_wrap_req0", 32'(last_done[0] - base), 32'd7);

        // T4 fairness with immediate re-strobe, stats snapshot at the 20th grant
        do_reset();
        n_done_total = 0; seq.delete();
        for (int i = 0; i < N; i++) ndone[i] = 0;
        set_req(0, BASE + 32'h200, '0, 1'b0);
        set_req(1, BASE + 32'h240, '0, 1'b0);
        for (int k = 0; k < 400 && n_done_total < 20; k++) begin
            for (int i = 0; i < N; i++) stb[i] = !r_pend[i];
            step(stb);
        end
        chk("t4_total", 32'(n_done_total), 32'd20);
        chk("t4_req0", 32'(ndone[0]), 32'd10);
        chk("t4_req1", 32'(ndone[1]), 32'd10);
        viol = 0;
        for (int k = 1; k < seq.size(); k++) if (seq[k] == seq[k-1]) viol++;
        chk("t4_alternation", 32'(viol), 32'd0);
`ifdef MEM_ARB_STATS_EN
        t7_exp = {32'd10, 32'd10};
`else
        t7_exp = '0;
`endif
        chk("t7_stats", stat_snap, t7_exp);
        idle(20);

        // T5 duplicate strobe while pending is ignored
        nd0 = ndone[0];
        set_req(0, BASE + 32'h140, '0, 1'b0);
        step(2'b01);
        idle(2);
        set_req(0, BASE + 32'h380, '0, 1'b0);
        step(2'b01);
        idle(12);
        chk("t5_single_done", 32'(ndone[0] - nd0), 32'd1);
        chk("t5_addr_A", mstb_addr, BASE + 32'h140);

        // T6 reset during WAIT
        nd0 = ndone[0];
        set_req(0, BASE + 32'h40, '0, 1'b0);
        step(2'b01);
        idle(4);
        do_reset();
        idle(10);
        chk("t6_no_done", 32'(ndone[0] - nd0), 32'd0);
        base = cyc;
        step(2'b01);
        idle(9);
        chk("t6_after_reset_done", 32'(last_done[0] - base), 32'd7);

        // Random traffic
        for (int k = 0; k < 500; k++) begin
            for (int i = 0; i < N; i++) begin
                set_req(i, BASE + (32'($urandom_range(0, 15)) << 6),
                        {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
                stb[i] = ($urandom_range(0, 2) == 0);
            end
            step(stb);
        end
        idle(30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
